// File: rtl/monitor_catraca_if.sv
// Bundle between the turnstile controller outputs and the monitor.
// The slave side is the monitor; the master side drives the controller nets.
interface monitor_catraca_if;
  logic [6:0] display;
  logic [1:0] ledVerde;
  logic [1:0] ledVermelho;
  logic [1:0] seletor;
  logic       limpaErro;
  logic [2:0] estadoAtual;
  logic       valido;
  logic       erro;
  logic [7:0] contEntradas;
  logic [7:0] contSaidas;
  logic [7:0] contAlarmes;
  logic [6:0] hexMonitor;

  modport slave (
    input  display, ledVerde, ledVermelho,
    input  seletor, limpaErro,
    output estadoAtual, valido, erro,
    output contEntradas, contSaidas, contAlarmes,
    output hexMonitor
  );

  modport master (
    output display, ledVerde, ledVermelho,
    output seletor, limpaErro,
    input  estadoAtual, valido, erro,
    input  contEntradas, contSaidas, contAlarmes,
    input  hexMonitor
  );
endinterface

// File: rtl/monitor_catraca.sv
// Rebuilds the turnstile controller state from its display/LED outputs,
// rejects 1-cycle glitches, flags illegal codes and counts events.
module monitor_catraca (
  input  logic clock,
  input  logic reset,
  monitor_catraca_if.slave bus
);

  localparam logic [10:0] S1_ILL = 11'h7FF;

  logic [10:0] s1_q;
  logic [3:0]  cand_q;
  logic [2:0]  est_q, est_d;
  logic        valido_q, valido_d;
  logic        erro_q, erro_d;
  logic [1:0]  run_q, run_d;
  logic [7:0]  ent_q, ent_d;
  logic [7:0]  sai_q, sai_d;
  logic [7:0]  ala_q, ala_d;
  logic [3:0]  dec;
  logic        acc;
  logic        evt;
  logic [3:0]  nib;

  // Returns {legal, state code}
  function automatic logic [3:0] decode(input logic [10:0] v);
    case (v)
      {7'b1111001, 2'b00, 2'b00}: decode = 4'b1000;
      {7'b0100100, 2'b01, 2'b00}: decode = 4'b1001;
      {7'b0110000, 2'b00, 2'b01}: decode = 4'b1010;
      {7'b0011001, 2'b10, 2'b10}: decode = 4'b1011;
      {7'b0010010, 2'b00, 2'b00}: decode = 4'b1100;
      default:                    decode = 4'b0000;
    endcase
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  function automatic logic [7:0] inc_sat(input logic [7:0] c);
    inc_sat = (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  always_comb begin
    dec = decode(s1_q);
    acc = dec[3] & cand_q[3] & (dec[2:0] == cand_q[2:0]);
    evt = acc & (~valido_q | (dec[2:0] != est_q));
    est_d    = acc ? dec[2:0] : est_q;
    valido_d = valido_q | acc;
    ent_d = ent_q;
    sai_d = sai_q;
    ala_d = ala_q;
    if (evt) begin
      case (dec[2:0])
        3'b001:  ent_d = inc_sat(ent_q);
        3'b100:  sai_d = inc_sat(sai_q);
        3'b010:  ala_d = inc_sat(ala_q);
        default: ;
      endcase
    end
    if (dec[3])
      run_d = 2'd0;
    else
      run_d = (run_q == 2'd3) ? run_q : run_q + 2'd1;
    // Set beats clear when both happen on one edge
    erro_d = (run_d == 2'd3) | (erro_q & ~bus.limpaErro);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q     <= S1_ILL;
      cand_q   <= 4'b0000;
      est_q    <= 3'b000;
      valido_q <= 1'b0;
      erro_q   <= 1'b0;
      run_q    <= 2'd0;
      ent_q    <= 8'd0;
      sai_q    <= 8'd0;
      ala_q    <= 8'd0;
    end else begin
      s1_q     <= {bus.display, bus.ledVerde, bus.ledVermelho};
      cand_q   <= dec;
      est_q    <= est_d;
      valido_q <= valido_d;
      erro_q   <= erro_d;
      run_q    <= run_d;
      ent_q    <= ent_d;
      sai_q    <= sai_d;
      ala_q    <= ala_d;
    end
  end

  always_comb begin
    case (bus.seletor)
      2'b00:   nib = ent_q[3:0];
      2'b01:   nib = sai_q[3:0];
      2'b10:   nib = ala_q[3:0];
      default: nib = {1'b0, est_q} + 4'd1;
    endcase
    if (bus.seletor == 2'b11 && !valido_q)
      bus.hexMonitor = 7'b0111111;
    else
      bus.hexMonitor = hex7(nib);
  end

  assign bus.estadoAtual  = est_q;
  assign bus.valido       = valido_q;
  assign bus.erro         = erro_q;
  assign bus.contEntradas = ent_q;
  assign bus.contSaidas   = sai_q;
  assign bus.contAlarmes  = ala_q;

endmodule

// File: doc/monitor_catraca.md
# monitor_catraca

Decoder-side monitor for the turnstile controller: it reads back the controller's 7-segment state code and LED pair outputs and reconstructs the controller's current state. It filters single-cycle glitches and flags illegal output combinations. It also keeps saturating event counters (entries, exits, metal alarms) for a selected counter or state to be shown on a second 7-segment digit. It sits beside the controller in the board top level, wired to the controller's `display`, `ledVerde` and `ledVermelho` nets.

## Interface
- No parameters. Counter width is fixed at 8 bits.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `display`  in  7  controller 7-seg code, active-low, bit order {g,f,e,d,c,b,a}.
- `ledVerde`  in  2  controller green LED pair.
- `ledVermelho`  in  2  controller red LED pair.
- `seletor`  in  2  display select: 00 entries, 01 exits, 10 alarms, 11 decoded state.
- `limpaErro`  in  1  synchronous clear of the sticky `erro` flag.
- `estadoAtual`  out  3  accepted controller state: A=000, B=001, C=010, D=011, E=100.
- `valido`  out  1  at least one state has been accepted since reset.
- `erro`  out  1  sticky illegal-combination flag.
- `contEntradas`, `contSaidas`, `contAlarmes`  out  8 each  event counters.
- `hexMonitor`  out  7  active-low 7-seg output, same bit order as `display`.

## Operation
- **Stage 1 (input register).** {`display`, `ledVerde`, `ledVermelho`} are registered every edge. No logic acts on the raw inputs.
- **Legal combinations.** Each entry below gives display code, `ledVerde`, `ledVermelho`. Any other 11-bit value is illegal.
  - A: 1111001, 00, 00.
  - B: 0100100, 01, 00.
  - C: 0110000, 00, 01.
  - D: 0011001, 10, 10.
  - E: 0010010, 00, 00.
- **Candidate register.** Loaded every edge with the decode of stage 1, or with an "illegal" marker.
- **Acceptance.** A legal stage-1 decode equal to the current candidate is accepted: `estadoAtual` takes that code and `valido` is set (stays set until reset).
- **Events.** Events fire only on accepted transitions where the new state differs from the old state, or on the first acceptance after reset:
  - Entering B increments `contEntradas`.
  - Entering E increments `contSaidas`.
  - Entering C increments `contAlarmes`.
  - Entering A or D increments no counter.
- **Reset value of `estadoAtual` is A.** A first acceptance of A after reset therefore counts no event.
- **Counters saturate at 255.** No wrap-around.
- **Illegal tracking.** A 2-bit illegal run counter increments, saturating at 3, on each edge where the stage-1 decode is illegal. It resets to 0 on any legal decode.
  - `erro` sets when the run counter reaches 3.
  - `estadoAtual` and the counters hold during illegal input.
- **`limpaErro`.** Clears `erro` at the edge.
  - If the set condition is true on the same edge, set wins.
  - `limpaErro` does not clear the run counter.
- **`hexMonitor` (combinational from registered values).**
  - For seletor 00/01/10: active-low hex of the selected counter's low nibble. Examples: 0 = 1000000, 1 = 1111001, A = 0001000, F = 0001110.
  - For seletor 11: digits 1–5 for states A–E, using the controller's codes. Shows 0111111 ("-") while `valido` = 0.

## Timing
- **Reset values:**
  - `estadoAtual` = 000.
  - `valido` = 0, `erro` = 0.
  - All counters = 0.
  - Stage 1 and candidate hold an illegal marker.
  - `hexMonitor` = 1000000 (seletor 00 at reset).
- **Acceptance latency.** Input stable before edge t is captured in stage 1 at t and in the candidate at t+1. It is accepted at t+2, and any counter increment happens on that same edge t+2.
- **Glitch rejection.**
  - A 1-cycle pulse of a different legal code is never accepted.
  - A 2-cycle pulse is accepted.
- **Error latency.** Illegal input held from before edge t through t+2: stage 1 shows illegal values at t, t+1 and t+2. `erro` rises after edge t+3.
- **Reset mid-operation.** Asynchronous reset forces the reset values immediately, regardless of `clock`. The first acceptance after reset release follows the normal 3-edge latency.
- `seletor` changes affect `hexMonitor` in the same cycle, with no latency.

## Test plan
- Reset, then hold A for 4 cycles → `valido` = 1 after the 3rd edge, `estadoAtual` = 000, all counters 0, seletor=11 shows 1111001.
- Sequence A→B→A→E→A→C, each held 4 cycles → `contEntradas` = 1, `contSaidas` = 1, `contAlarmes` = 1; seletor=10 gives `hexMonitor` = 1111001.
- Hold A, inject B for exactly 1 cycle → `estadoAtual` stays 000 and `contEntradas` = 0. Repeat with a 2-cycle B pulse → `contEntradas` = 1.
- Apply display = 1111001 with `ledVerde` = 11 for 3 cycles → `erro` = 1 after the 4th edge and `estadoAtual` unchanged. Pulse `limpaErro` while still illegal → `erro` stays 1. Restore A, then pulse `limpaErro` → `erro` = 0.
- Toggle A↔B 300 times → `contEntradas` = 255 (saturated) and `hexMonitor` with seletor=00 = 0001110.
- Assert `reset` asynchronously mid-cycle with counters nonzero → all outputs at reset values before the next edge.
